// File: rtl/id_ex_pipeline_reg.sv
// rtl/id_ex_pipeline_reg.sv - ID/EX pipeline register with bubble insert, hold and load-use bubble counter
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   Stall, Flush, DataHazard hold / flush bubble / load-use bubble controls
//   ID*                      decoded ID-stage bundle (operands already forwarded)
//   EX*                      registered bundle presented to EX
//   BubbleCount              wrap-around count of load-use bubbles on valid ID slots

module id_ex_pipeline_reg #(
  parameter int unsigned ALU_OP_WIDTH = 4,
  parameter int unsigned BRANCH_WIDTH = 3,
  parameter int unsigned COUNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    Stall,
  input  logic                    Flush,
  input  logic                    DataHazard,
  input  logic                    IDValid,
  input  logic [31:0]             IDPc,
  input  logic [31:0]             IDPc4,
  input  logic [31:0]             IDExt,
  input  logic [31:0]             IDRegisterData1,
  input  logic [31:0]             IDRegisterData2,
  input  logic [4:0]              IDWriteRegister,
  input  logic                    IDRegisterFileWriteEnable,
  input  logic [1:0]              IDRegisterFileWriteSelect,
  input  logic [ALU_OP_WIDTH-1:0] IDAluOp,
  input  logic                    IDAluBSelect,
  input  logic                    IDDramWriteEnable,
  input  logic [BRANCH_WIDTH-1:0] IDBranchType,
  output logic                    EXValid,
  output logic [31:0]             EXPc,
  output logic [31:0]             EXPc4,
  output logic [31:0]             EXExt,
  output logic [31:0]             EXRegisterData1,
  output logic [31:0]             EXRegisterData2,
  output logic [4:0]              EXWriteRegister,
  output logic                    EXRegisterFileWriteEnable,
  output logic [1:0]              EXRegisterFileWriteSelect,
  output logic [ALU_OP_WIDTH-1:0] EXAluOp,
  output logic                    EXAluBSelect,
  output logic                    EXDramWriteEnable,
  output logic [BRANCH_WIDTH-1:0] EXBranchType,
  output logic [COUNT_WIDTH-1:0]  BubbleCount
);

  typedef struct packed {
    logic                    valid;
    logic [31:0]             pc;
    logic [31:0]             pc4;
    logic [31:0]             ext;
    logic [31:0]             rd1;
    logic [31:0]             rd2;
    logic [4:0]              wr_reg;
    logic                    rf_we;
    logic [1:0]              rf_wsel;
    logic [ALU_OP_WIDTH-1:0] alu_op;
    logic                    alu_bsel;
    logic                    dram_we;
    logic [BRANCH_WIDTH-1:0] br_type;
  } bundle_t;

  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  bundle_t                 id_bundle;
  bundle_t                 bundle_d;
  bundle_t                 bundle_q;
  logic [COUNT_WIDTH-1:0]  count_d;
  logic [COUNT_WIDTH-1:0]  count_q;

  always_comb begin
    id_bundle.valid    = IDValid;
    id_bundle.pc       = IDPc;
    id_bundle.pc4      = IDPc4;
    id_bundle.ext      = IDExt;
    id_bundle.rd1      = IDRegisterData1;
    id_bundle.rd2      = IDRegisterData2;
    id_bundle.wr_reg   = IDWriteRegister;
    id_bundle.rf_we    = IDRegisterFileWriteEnable;
    id_bundle.rf_wsel  = IDRegisterFileWriteSelect;
    id_bundle.alu_op   = IDAluOp;
    id_bundle.alu_bsel = IDAluBSelect;
    id_bundle.dram_we  = IDDramWriteEnable;
    id_bundle.br_type  = IDBranchType;
  end

  // Flush outranks Stall so a squashed instruction never lingers in EX
  // during a memory wait; Stall outranks DataHazard so a held load-use
  // pair is neither bubbled nor counted until the stall lifts.
  always_comb begin
    bundle_d = bundle_q;
    count_d  = count_q;
    if (Flush) begin
      bundle_d = '0;
    end else if (Stall) begin
      bundle_d = bundle_q;
    end else if (DataHazard) begin
      bundle_d = '0;
      if (IDValid) begin
        count_d = count_q + COUNT_ONE;
      end
    end else begin
      bundle_d = id_bundle;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bundle_q <= '0;
      count_q  <= '0;
    end else begin
      bundle_q <= bundle_d;
      count_q  <= count_d;
    end
  end

  assign EXValid                   = bundle_q.valid;
  assign EXPc                      = bundle_q.pc;
  assign EXPc4                     = bundle_q.pc4;
  assign EXExt                     = bundle_q.ext;
  assign EXRegisterData1           = bundle_q.rd1;
  assign EXRegisterData2           = bundle_q.rd2;
  assign EXWriteRegister           = bundle_q.wr_reg;
  assign EXRegisterFileWriteEnable = bundle_q.rf_we;
  assign EXRegisterFileWriteSelect = bundle_q.rf_wsel;
  assign EXAluOp                   = bundle_q.alu_op;
  assign EXAluBSelect              = bundle_q.alu_bsel;
  assign EXDramWriteEnable         = bundle_q.dram_we;
  assign EXBranchType              = bundle_q.br_type;
  assign BubbleCount               = count_q;

endmodule

// File: tb/tb_id_ex_pipeline_reg.sv
// tb/tb_id_ex_pipeline_reg.sv - self-checking bench for id_ex_pipeline_reg
module tb_id_ex_pipeline_reg;

  localparam int CW = 4;
  localparam int BW = 178;

  logic clk = 1'b0;
  logic rst;
  logic Stall, Flush, DataHazard;
  logic IDValid;
  logic [31:0] IDPc, IDPc4, IDExt, IDRegisterData1, IDRegisterData2;
  logic [4:0] IDWriteRegister;
  logic IDRegisterFileWriteEnable;
  logic [1:0] IDRegisterFileWriteSelect;
  logic [3:0] IDAluOp;
  logic IDAluBSelect, IDDramWriteEnable;
  logic [2:0] IDBranchType;
  logic EXValid;
  logic [31:0] EXPc, EXPc4, EXExt, EXRegisterData1, EXRegisterData2;
  logic [4:0] EXWriteRegister;
  logic EXRegisterFileWriteEnable;
  logic [1:0] EXRegisterFileWriteSelect;
  logic [3:0] EXAluOp;
  logic EXAluBSelect, EXDramWriteEnable;
  logic [2:0] EXBranchType;
  logic [CW-1:0] BubbleCount;

  int checks = 0;
  int failures = 0;

  logic [BW-1:0] exp_ex;
  int            exp_cnt;
  logic [BW-1:0] obs;

  always #5 clk = ~clk;

  id_ex_pipeline_reg #(.ALU_OP_WIDTH(4), .BRANCH_WIDTH(3), .COUNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .Stall(Stall), .Flush(Flush), .DataHazard(DataHazard),
    .IDValid(IDValid), .IDPc(IDPc), .IDPc4(IDPc4), .IDExt(IDExt),
    .IDRegisterData1(IDRegisterData1), .IDRegisterData2(IDRegisterData2),
    .IDWriteRegister(IDWriteRegister), .IDRegisterFileWriteEnable(IDRegisterFileWriteEnable),
    .IDRegisterFileWriteSelect(IDRegisterFileWriteSelect), .IDAluOp(IDAluOp),
    .IDAluBSelect(IDAluBSelect), .IDDramWriteEnable(IDDramWriteEnable), .IDBranchType(IDBranchType),
    .EXValid(EXValid), .EXPc(EXPc), .EXPc4(EXPc4), .EXExt(EXExt),
    .EXRegisterData1(EXRegisterData1), .EXRegisterData2(EXRegisterData2),
    .EXWriteRegister(EXWriteRegister), .EXRegisterFileWriteEnable(EXRegisterFileWriteEnable),
    .EXRegisterFileWriteSelect(EXRegisterFileWriteSelect), .EXAluOp(EXAluOp),
    .EXAluBSelect(EXAluBSelect), .EXDramWriteEnable(EXDramWriteEnable), .EXBranchType(EXBranchType),
    .BubbleCount(BubbleCount)
  );

  assign obs = {EXValid, EXPc, EXPc4, EXExt, EXRegisterData1, EXRegisterData2, EXWriteRegister,
                EXRegisterFileWriteEnable, EXRegisterFileWriteSelect, EXAluOp, EXAluBSelect,
                EXDramWriteEnable, EXBranchType};

  function automatic logic [BW-1:0] rand_bundle();
    logic [191:0] tmp;
    tmp = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return tmp[BW-1:0];
  endfunction

  function automatic logic [BW-1:0] make_bundle(input logic valid, input logic [31:0] pc,
                                                 input logic [31:0] rd1, input logic [4:0] wr,
                                                 input logic we);
    logic [BW-1:0] v;
    v = '0;
    v[177] = valid;
    v[176:145] = pc;
    v[80:49] = rd1;
    v[16:12] = wr;
    v[11] = we;
    return v;
  endfunction

  // Reference: the EX register is the ID bundle one edge later, zero for a
  // bubble, unchanged on a hold; the counter counts valid load-use bubbles mod 16.
  task automatic model_edge(input logic f, input logic s, input logic d, input logic [BW-1:0] v);
    if (f) exp_ex = '0;
    else if (s) exp_ex = exp_ex;
    else if (d) begin
      exp_ex = '0;
      if (v[177]) exp_cnt = (exp_cnt + 1) % 16;
    end else exp_ex = v;
  endtask

  task automatic edge_cycle(input logic f, input logic s, input logic d, input logic [BW-1:0] v);
    @(negedge clk);
    Flush = f; Stall = s; DataHazard = d;
    {IDValid, IDPc, IDPc4, IDExt, IDRegisterData1, IDRegisterData2, IDWriteRegister,
     IDRegisterFileWriteEnable, IDRegisterFileWriteSelect, IDAluOp, IDAluBSelect,
     IDDramWriteEnable, IDBranchType} = v;
    model_edge(f, s, d, v);
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if (obs !== '0 || BubbleCount !== '0) begin
      failures++;
      $display("FAIL reset_initial ex=%h cnt=%0d expected all zero", obs, BubbleCount);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_ex = '0; exp_cnt = 0;
    edge_cycle(1'b0, 1'b0, 1'b1, make_bundle(1'b1, 32'h0, 32'h0, 5'd0, 1'b0));
    edge_cycle(1'b0, 1'b0, 1'b0, make_bundle(1'b1, 32'h0000_1000, 32'h1, 5'd3, 1'b1));
    checks++;
    if (EXPc !== 32'h0000_1000 || EXValid !== 1'b1 || BubbleCount !== 4'd1) begin
      failures++;
      $display("FAIL reset_preload pc=%h valid=%b cnt=%0d expected 00001000 1 1", EXPc, EXValid, BubbleCount);
    end
    rst = 1'b1;
    #1;
    exp_ex = '0; exp_cnt = 0;
    checks++;
    if (obs !== '0 || BubbleCount !== '0) begin
      failures++;
      $display("FAIL reset_async ex=%h cnt=%0d expected all zero before next edge", obs, BubbleCount);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_pass_through();
    edge_cycle(1'b0, 1'b0, 1'b0, make_bundle(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 5'd7, 1'b1));
    checks++;
    if (EXPc !== 32'h0000_0040 || EXRegisterData1 !== 32'hDEAD_BEEF || EXWriteRegister !== 5'd7 ||
        EXRegisterFileWriteEnable !== 1'b1 || EXValid !== 1'b1) begin
      failures++;
      $display("FAIL pass_through pc=%h rd1=%h wr=%0d we=%b valid=%b", EXPc, EXRegisterData1,
               EXWriteRegister, EXRegisterFileWriteEnable, EXValid);
    end
    for (int i = 0; i < 4; i++) begin
      edge_cycle(1'b0, 1'b0, 1'b0, rand_bundle());
      checks++;
      if (obs !== exp_ex) begin
        failures++;
        $display("FAIL pass_random ex=%h expected %h", obs, exp_ex);
      end
    end
  endtask

  task automatic test_load_use();
    logic [BW-1:0] v;
    int cnt0;
    v = rand_bundle();
    v[177] = 1'b1; v[11] = 1'b1; v[3] = 1'b1;
    cnt0 = exp_cnt;
    edge_cycle(1'b0, 1'b0, 1'b1, v);
    checks++;
    if (EXValid !== 1'b0 || EXRegisterFileWriteEnable !== 1'b0 || EXDramWriteEnable !== 1'b0 ||
        obs !== '0 || int'(BubbleCount) !== (cnt0 + 1) % 16) begin
      failures++;
      $display("FAIL load_use_bubble ex=%h cnt=%0d expected zero bundle cnt %0d", obs, BubbleCount, (cnt0 + 1) % 16);
    end
    edge_cycle(1'b0, 1'b0, 1'b0, v);
    checks++;
    if (obs !== v || int'(BubbleCount) !== exp_cnt) begin
      failures++;
      $display("FAIL load_use_reload ex=%h cnt=%0d expected %h %0d", obs, BubbleCount, v, exp_cnt);
    end
  endtask

  task automatic test_stall();
    logic [BW-1:0] snap, v;
    int cnt0;
    edge_cycle(1'b0, 1'b0, 1'b0, rand_bundle());
    snap = obs;
    cnt0 = int'(BubbleCount);
    for (int i = 0; i < 3; i++) begin
      edge_cycle(1'b0, 1'b1, 1'b0, rand_bundle());
      checks++;
      if (obs !== exp_ex || obs !== snap || int'(BubbleCount) !== cnt0) begin
        failures++;
        $display("FAIL stall_hold cycle=%0d ex=%h cnt=%0d expected %h %0d", i, obs, BubbleCount, exp_ex, cnt0);
      end
    end
    v = rand_bundle();
    edge_cycle(1'b0, 1'b0, 1'b0, v);
    checks++;
    if (obs !== v) begin
      failures++;
      $display("FAIL stall_release ex=%h expected %h", obs, v);
    end
  endtask

  task automatic test_simultaneous();
    logic [BW-1:0] v, snap;
    int cnt0;
    v = rand_bundle();
    v[177] = 1'b1;
    edge_cycle(1'b0, 1'b0, 1'b0, v);
    cnt0 = exp_cnt;
    edge_cycle(1'b1, 1'b1, 1'b1, v);
    checks++;
    if (obs !== '0 || int'(BubbleCount) !== cnt0) begin
      failures++;
      $display("FAIL flush_stall_hazard ex=%h cnt=%0d expected zero bundle cnt %0d", obs, BubbleCount, cnt0);
    end
    edge_cycle(1'b0, 1'b0, 1'b0, v);
    snap = v;
    v = rand_bundle();
    v[177] = 1'b1;
    edge_cycle(1'b0, 1'b1, 1'b1, v);
    checks++;
    if (obs !== snap || int'(BubbleCount) !== cnt0) begin
      failures++;
      $display("FAIL stall_hazard_hold ex=%h cnt=%0d expected %h %0d", obs, BubbleCount, snap, cnt0);
    end
    edge_cycle(1'b1, 1'b0, 1'b0, v);
    checks++;
    if (obs !== '0 || int'(BubbleCount) !== cnt0) begin
      failures++;
      $display("FAIL flush_only ex=%h cnt=%0d expected zero bundle cnt %0d", obs, BubbleCount, cnt0);
    end
    v[177] = 1'b0;
    edge_cycle(1'b0, 1'b0, 1'b1, v);
    checks++;
    if (obs !== '0 || int'(BubbleCount) !== cnt0) begin
      failures++;
      $display("FAIL hazard_invalid_nocount ex=%h cnt=%0d expected cnt %0d", obs, BubbleCount, cnt0);
    end
  endtask

  task automatic test_wrap();
    logic [BW-1:0] v;
    logic wrapped;
    wrapped = 1'b0;
    for (int i = 0; i < 16; i++) begin
      v = rand_bundle();
      v[177] = 1'b1;
      edge_cycle(1'b0, 1'b0, 1'b1, v);
      if (exp_cnt == 0) wrapped = 1'b1;
      checks++;
      if (int'(BubbleCount) !== exp_cnt) begin
        failures++;
        $display("FAIL wrap_count step=%0d cnt=%0d expected %0d", i, BubbleCount, exp_cnt);
      end
    end
    checks++;
    if (!wrapped) begin
      failures++;
      $display("FAIL wrap_seen counter never returned to 0 (model cnt=%0d)", exp_cnt);
    end
  endtask

  task automatic test_random();
    logic f, s, d;
    for (int i = 0; i < 300; i++) begin
      f = ($urandom % 8) == 0;
      s = ($urandom % 5) == 0;
      d = ($urandom % 4) == 0;
      edge_cycle(f, s, d, rand_bundle());
      checks++;
      if (obs !== exp_ex || int'(BubbleCount) !== exp_cnt) begin
        failures++;
        $display("FAIL random i=%0d f=%b s=%b d=%b ex=%h cnt=%0d expected %h %0d", i, f, s, d,
                 obs, BubbleCount, exp_ex, exp_cnt);
      end
    end
  endtask

  initial begin
    Flush = 1'b0; Stall = 1'b0; DataHazard = 1'b0;
    {IDValid, IDPc, IDPc4, IDExt, IDRegisterData1, IDRegisterData2, IDWriteRegister,
     IDRegisterFileWriteEnable, IDRegisterFileWriteSelect, IDAluOp, IDAluBSelect,
     IDDramWriteEnable, IDBranchType} = '0;
    exp_ex = '0;
    exp_cnt = 0;
    test_reset();
    test_pass_through();
    test_load_use();
    test_stall();
    test_simultaneous();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_pipeline_reg.md
# id_ex_pipeline_reg

ID/EX pipeline register: the sequential stage directly downstream of data hazard detection. It captures the decoded ID-stage bundle each cycle, including the forwarded NewRegisterData1/NewRegisterData2 operands, and presents it to EX. It inserts a bubble on a load-use DataHazard or a control-hazard Flush, and holds its contents on a global Stall. It also keeps a wrap-around count of load-use bubbles for performance debug.

## Interface
Parameters:
- ALU_OP_WIDTH, 4, ALU operation code width
- BRANCH_WIDTH, 3, branch-type code width; value 0 = no branch
- COUNT_WIDTH, 16, BubbleCount width

Ports:
- clk  in  1  rising-edge clock; the block's only clock
- rst  in  1  reset; asynchronous, active-high
- Stall  in  1  global hold (e.g. memory wait); freezes every EX* output and BubbleCount
- Flush  in  1  taken branch/jump resolved in EX; discards the ID bundle
- DataHazard  in  1  load-use hazard from data_hazard_detection
- IDValid  in  1  ID slot holds a real instruction
- IDPc, IDPc4, IDExt  in  32 each  PC, PC+4, sign-extended immediate
- IDRegisterData1, IDRegisterData2  in  32 each  forwarded operands (NewRegisterData1/2)
- IDWriteRegister  in  5  destination register
- IDRegisterFileWriteEnable  in  1  register-file write enable
- IDRegisterFileWriteSelect  in  2  WB source: `WB_PC4/`WB_SEXT/`WB_ALU/`WB_DRAM
- IDAluOp  in  ALU_OP_WIDTH  ALU operation
- IDAluBSelect  in  1  ALU B operand: 0 = register data 2, 1 = Ext
- IDDramWriteEnable  in  1  store enable
- IDBranchType  in  BRANCH_WIDTH  branch/jump kind
- EXValid  out  1  EX slot holds a real instruction
- EXPc, EXPc4, EXExt, EXRegisterData1, EXRegisterData2  out  32 each  registered copies of the ID fields
- EXWriteRegister, EXRegisterFileWriteEnable, EXRegisterFileWriteSelect, EXAluOp, EXAluBSelect, EXDramWriteEnable, EXBranchType  out  same widths as ID  registered copies of the ID fields
- BubbleCount  out  COUNT_WIDTH  number of load-use bubbles inserted

## Operation
- All outputs are registers. Next-state priority on each rising clk edge:
  1. Flush = 1: load a bubble.
  2. Stall = 1: hold all state.
  3. DataHazard = 1: load a bubble.
  4. Otherwise: load the ID bundle; EXValid <= IDValid.
- A bubble sets every EX* output to 0:
  - EXValid, EXRegisterFileWriteEnable and EXDramWriteEnable are 0.
  - EXBranchType is 0 (no branch) and EXWriteRegister is 5'b00000.
  - The bubble therefore has no architectural effect downstream.
- Flush overrides Stall: a taken branch is never held in EX across a stall.
- BubbleCount:
  - Increments by 1 on an edge where the DataHazard bubble branch is taken (Flush = 0, Stall = 0, DataHazard = 1) and IDValid = 1.
  - Bubbles caused by Flush are not counted.
  - Wraps from all-ones to 0; no saturation.
- The block does not stall PC or IF/ID. The upstream control holds those using the same DataHazard/Stall signals.
- No qualification of DataHazard is performed. The hazard unit already masks x0 and disabled reads.

## Timing
- Latency: 1 cycle, ID to EX.
- rst asserted clears every EX* output and BubbleCount to 0 immediately, without waiting for clk. This includes assertion mid-operation.
- The first capture is on the first rising clk edge after rst deasserts.
- Load-use sequence:
  - Cycle N: DataHazard = 1, so EX becomes a bubble at edge N+1.
  - Upstream holds ID, and in cycle N+1 the hazard unit sees the load in MEM and forwards MEMDramData. DataHazard is then 0.
  - The dependent instruction enters EX at edge N+2.
- Stall held for k cycles: EX outputs are identical across all k+1 observed cycles, and BubbleCount is unchanged.
- Flush, Stall and DataHazard all 1 on the same edge: the result is a bubble, and BubbleCount does not increment.
- Stall and DataHazard both 1 (Flush = 0): the result is a hold, and no count.

## Test plan
- Reset: preload with IDPc = 32'h0000_1000 and IDValid = 1, clock once, then assert rst between edges. All EX* outputs and BubbleCount must read 0 before the next edge.
- Pass-through: IDPc = 32'h0000_0040, IDRegisterData1 = 32'hDEAD_BEEF, IDWriteRegister = 5'd7, IDRegisterFileWriteEnable = 1, IDValid = 1. One edge later EX shows the same values and EXValid = 1.
- Load-use: DataHazard = 1 for one cycle with IDValid = 1. The next EX is a bubble (EXValid = 0, EXRegisterFileWriteEnable = 0, EXDramWriteEnable = 0) and BubbleCount goes 0 -> 1. The following edge loads the held ID bundle.
- Stall: Stall = 1 for 3 cycles while the ID inputs change every cycle. EX outputs stay frozen at the pre-stall values and BubbleCount is unchanged. After release, the current ID bundle loads.
- Simultaneous: Flush = Stall = DataHazard = 1 gives a bubble with BubbleCount unchanged. Stall = DataHazard = 1 with Flush = 0 gives a hold.
- Wrap: with COUNT_WIDTH = 4, force 16 counted load-use bubbles. BubbleCount goes 15 -> 0.
